// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and result-word layout for the ME result sequencer.
// No ports; imported by me_result_sequencer and its bench.
package me_pkg;

    localparam int unsigned SW_LENGTH = 32;
    localparam int unsigned TB_LENGTH = 8;

    // Raw search position that corresponds to zero displacement (19 for SW 32 / TB 8).
    localparam int unsigned MV_BIAS_DEF = (SW_LENGTH + TB_LENGTH) / 2 - 1;

    localparam int unsigned MVEC_W = 10;   // raw {vert[4:0], horz[4:0]}
    localparam int unsigned MV_W   = 6;    // signed motion-vector component

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAPT = 3'd2,
        ST_DROP = 3'd3,
        ST_ADV  = 3'd4,
        ST_FIN  = 3'd5
    } me_state_e;

    // Result word {mb_y, mb_x, mv_v, mv_h, sad}: LSB offsets of each field.
    function automatic int unsigned res_mvh_lsb(int unsigned sad_w);
        return sad_w;
    endfunction

    function automatic int unsigned res_mvv_lsb(int unsigned sad_w);
        return sad_w + MV_W;
    endfunction

    function automatic int unsigned res_mbx_lsb(int unsigned sad_w);
        return sad_w + 2 * MV_W;
    endfunction

    function automatic int unsigned res_mby_lsb(int unsigned sad_w, int unsigned xw);
        return sad_w + 2 * MV_W + xw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO whose head entry is held in an output register.
// Ports: clk, rst_n (async, active-low); push/push_data write; pop consumes head;
// rd_valid/rd_data registered head; full, empty, count occupancy.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             push_c, pop_c;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // Pointer/occupancy update and next head; a push into a FIFO that is
    // empty after this cycle's pop bypasses the array straight to the head.
    always_comb begin
        push_c     = push && !full;
        pop_c      = pop && !empty;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_valid_d = (count_d != '0);
        rd_data_d  = rd_data_q;
        if (push_c && ((count_q - CNT_W'(pop_c)) == '0)) begin
            rd_data_d = push_data;
        end else if (count_d != '0) begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage array; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/me_result_sequencer.sv
// Walks a frame in raster order, runs the me_req/me_ack four-phase handshake
// per macroblock, converts the raw best position to a signed MV and buffers
// {mb_y, mb_x, mv_v, mv_h, sad} for a valid/ready consumer.
// Ports: clk, rst_n; start/busy/frame_done frame control; mb_x/mb_y current MB;
// me_req/me_ack/me_min_sad/me_min_mvec search-controller side;
// res_valid/res_ready/res_data result stream.
module me_result_sequencer
    import me_pkg::*;
#(
    parameter  int unsigned MB_COLS    = 40,
    parameter  int unsigned MB_ROWS    = 30,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned MV_BIAS    = MV_BIAS_DEF,
    parameter  int unsigned SAD_W      = 16,
    localparam int unsigned XW         = $clog2(MB_COLS),
    localparam int unsigned YW         = $clog2(MB_ROWS),
    localparam int unsigned RES_W      = res_mby_lsb(SAD_W, XW) + YW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [XW-1:0]     mb_x,
    output logic [YW-1:0]     mb_y,
    output logic              me_req,
    input  logic              me_ack,
    input  logic [SAD_W-1:0]  me_min_sad,
    input  logic [MVEC_W-1:0] me_min_mvec,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    me_state_e        state_q, state_d;
    logic [XW-1:0]    mb_x_q, mb_x_d;
    logic [YW-1:0]    mb_y_q, mb_y_d;
    logic             me_req_q, me_req_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             push_c;
    logic [MV_W-1:0]  mv_v_c, mv_h_c;
    logic [RES_W-1:0] push_data_c;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign mb_x       = mb_x_q;
    assign mb_y       = mb_y_q;
    assign me_req     = me_req_q;

    // Raw position minus bias, wrapping in 6 bits (no saturation).
    assign mv_v_c      = MV_W'({1'b0, me_min_mvec[9:5]}) - MV_W'(MV_BIAS);
    assign mv_h_c      = MV_W'({1'b0, me_min_mvec[4:0]}) - MV_W'(MV_BIAS);
    assign push_data_c = {mb_y_q, mb_x_q, mv_v_c, mv_h_c, me_min_sad};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            me_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            me_req_q     <= me_req_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state, macroblock stepping and FIFO push; registered outputs
    // are decoded from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        mb_x_d  = mb_x_q;
        mb_y_d  = mb_y_q;
        push_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mb_x_d  = '0;
                    mb_y_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (me_ack) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                // Holding me_req keeps the controller's outputs frozen while full.
                if (!fifo_full) begin
                    push_c  = 1'b1;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!me_ack) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                if (mb_x_q != XW'(MB_COLS - 1)) begin
                    mb_x_d  = mb_x_q + XW'(1);
                    state_d = ST_REQ;
                end else if (mb_y_q != YW'(MB_ROWS - 1)) begin
                    mb_x_d  = '0;
                    mb_y_d  = mb_y_q + YW'(1);
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        me_req_d     = (state_d == ST_REQ) || (state_d == ST_CAPT);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_FIN);
    end

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (res_ready),
        .rd_valid  (res_valid),
        .rd_data   (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Occupancy sanity: bounded count and head register tracking occupancy.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(FIFO_DEPTH));
    a_valid_tracks_empty: assert property (@(posedge clk) disable iff (!rst_n)
        res_valid == !fifo_empty);

endmodule
